// File: rtl/led_pkg.sv
// Shared types and helpers for the LED scan driver.
//   dig_code_t : 5-bit digit code, bit4 = decimal point, bits3:0 = hex value
//   SEG_OFF    : active-low segment pattern with every segment dark
//   seg7_dec   : digit code -> active-low {dp,g,f,e,d,c,b,a}
package led_pkg;

    typedef logic [4:0] dig_code_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [7:0] seg7_dec(dig_code_t code);
        logic [6:0] seg;
        unique case (code[3:0])
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return ~{code[4], seg};
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot timer for the LED scan driver.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   idx_o         digit index currently being scanned
//   in_blank_o    slot counter is inside the anti-ghost blank gap
//   frame_start_o counter and index are both zero (frame boundary)
module led_scan_timer #(
    parameter int unsigned N_DIG = 4,
    parameter int unsigned DWELL = 50000,
    parameter int unsigned BLANK = 8,
    localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx_o,
    output logic          in_blank_o,
    output logic          frame_start_o
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CW'(DWELL - 1)) begin
            cnt_d = '0;
            if (idx_q == IW'(N_DIG - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o         = idx_q;
    assign in_blank_o    = (cnt_q < CW'(BLANK));
    assign frame_start_o = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Digit codes are double-buffered: i_load fills the pending buffer, and the
// display buffer copies it only at a frame boundary so a frame never mixes
// old and new digits.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   i_digits  digit codes, digit k = i_digits[5k+4:5k]
//   i_load    strobe: capture i_digits into the pending buffer
//   o_seg     active-low segments {dp,g,f,e,d,c,b,a} (registered)
//   o_an      active-low digit enables (registered)
//   o_frame   one-cycle pulse after the display buffer updates (registered)
// Build option: define LED_SCAN_LZB_EN to enable leading-zero blanking.
module led_scan_driver #(
    parameter int unsigned N_DIG = 4,
    parameter int unsigned DWELL = 50000,
    parameter int unsigned BLANK = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5*N_DIG-1:0] i_digits,
    input  logic               i_load,
    output logic [7:0]         o_seg,
    output logic [N_DIG-1:0]   o_an,
    output logic               o_frame
);
    import led_pkg::*;

    localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [IW-1:0] idx;
    logic          in_blank;
    logic          frame_start;

    led_scan_timer #(
        .N_DIG (N_DIG),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .idx_o         (idx),
        .in_blank_o    (in_blank),
        .frame_start_o (frame_start)
    );

    logic [5*N_DIG-1:0] pend_q, pend_d;
    logic [5*N_DIG-1:0] disp_q, disp_d;
    logic [7:0]         seg_q, seg_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic               frame_q;

    dig_code_t        codes [N_DIG];
    logic [N_DIG-1:0] dig_blank;
    dig_code_t        code;

    // On the boundary cycle the display must already show the incoming
    // buffer, so the mux reads the next-state value rather than disp_q.
    always_comb begin
        pend_d = i_load ? i_digits : pend_q;
        disp_d = frame_start ? pend_q : disp_q;
        for (int k = 0; k < int'(N_DIG); k++) begin
            codes[k] = disp_d[5*k +: 5];
        end
    end

`ifdef LED_SCAN_LZB_EN
    // A digit blanks while it and every higher digit are 5'h00; a set dp makes
    // the code non-zero, which ends the run at and below that digit.
    always_comb begin
        logic run;
        dig_blank = '0;
        run       = 1'b1;
        for (int k = int'(N_DIG) - 1; k >= 0; k--) begin
            run          = run & (codes[k] == 5'h00);
            dig_blank[k] = run;
        end
        dig_blank[0] = 1'b0;
    end
`else
    assign dig_blank = '0;
`endif

    always_comb begin
        code = codes[idx];
        if (in_blank || dig_blank[idx]) begin
            an_d  = '1;
            seg_d = SEG_OFF;
        end else begin
            an_d  = ~(N_DIG'(1) << idx);
            seg_d = seg7_dec(code);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            disp_q  <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_start;
        end
    end

    assign o_seg   = seg_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with N_DIG=4, DWELL=6, BLANK=1.
// After each step the outputs reflect the scan state at the edge just taken;
// j counts states from the last frame boundary (cnt = j%6, digit = (j/6)%4).
module tb_led_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] i_digits;
    logic        i_load;
    logic [7:0]  o_seg;
    logic [3:0]  o_an;
    logic        o_frame;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    led_scan_driver #(
        .N_DIG (4),
        .DWELL (6),
        .BLANK (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_digits (i_digits),
        .i_load   (i_load),
        .o_seg    (o_seg),
        .o_an     (o_an),
        .o_frame  (o_frame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_an(input int j);
        if (j % 6 == 0) return 4'hF;
        return ~(4'b0001 << ((j / 6) % 4));
    endfunction

    // Step until o_frame is seen; afterwards the outputs reflect state j=0.
    task automatic sync_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (o_frame !== 1'b1 && n < 60);
        checks++;
        if (o_frame !== 1'b1) begin
            failures++;
            $display("FAIL sync_frame: o_frame=%b required 1 within 60 cycles", o_frame);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_load = 1'b0; i_digits = '0;
        repeat (3) step();
        checks += 3;
        if (o_an !== 4'hF) begin
            failures++; $display("FAIL reset_an: o_an=%h required F", o_an);
        end
        if (o_seg !== 8'hFF) begin
            failures++; $display("FAIL reset_seg: o_seg=%h required FF", o_seg);
        end
        if (o_frame !== 1'b0) begin
            failures++; $display("FAIL reset_frame: o_frame=%b required 0", o_frame);
        end
        rst = 1'b0;
        step();
        checks += 3;
        if (o_frame !== 1'b1) begin
            failures++; $display("FAIL first_frame: o_frame=%b required 1", o_frame);
        end
        if (o_an !== 4'hF) begin
            failures++; $display("FAIL first_an: o_an=%h required F", o_an);
        end
        if (o_seg !== 8'hFF) begin
            failures++; $display("FAIL first_seg: o_seg=%h required FF", o_seg);
        end
    endtask

    // Full frame of zeros: anode sequence, blank gap, one-hot and frame pulse.
    task automatic test_scan();
        for (int j = 1; j <= 24; j++) begin
            step();
            checks += 4;
            if (o_an !== exp_an(j)) begin
                failures++; $display("FAIL scan_an j=%0d: o_an=%h required %h", j, o_an, exp_an(j));
            end
            if (o_seg !== ((j % 6 == 0) ? 8'hFF : 8'hC0)) begin
                failures++; $display("FAIL scan_seg j=%0d: o_seg=%h", j, o_seg);
            end
            if (o_frame !== (j % 24 == 0)) begin
                failures++; $display("FAIL scan_frame j=%0d: o_frame=%b", j, o_frame);
            end
            if ($countones(~o_an) > 1) begin
                failures++; $display("FAIL scan_onehot j=%0d: o_an=%h required at most one low", j, o_an);
            end
        end
    endtask

    task automatic test_load();
        logic [7:0] exp_seg [4];
        exp_seg[0] = 8'h92; exp_seg[1] = 8'h88; exp_seg[2] = 8'h40; exp_seg[3] = 8'h0E;
        sync_frame();
        i_digits = {5'h1F, 5'h10, 5'h0A, 5'h05};
        i_load = 1'b1;
        step();
        i_load = 1'b0;
        sync_frame();
        for (int j = 1; j < 24; j++) begin
            step();
            if (j % 6 != 0) begin
                checks += 2;
                if (o_an !== exp_an(j)) begin
                    failures++; $display("FAIL load_an j=%0d: o_an=%h required %h", j, o_an, exp_an(j));
                end
                if (o_seg !== exp_seg[j / 6]) begin
                    failures++;
                    $display("FAIL load_seg j=%0d: o_seg=%h required %h", j, o_seg, exp_seg[j / 6]);
                end
            end
        end
    endtask

    task automatic test_mid_load();
        logic [7:0] old_seg [4];
        logic [7:0] new_seg [4];
        logic [7:0] e;
        old_seg[0] = 8'h92; old_seg[1] = 8'h88; old_seg[2] = 8'h40; old_seg[3] = 8'h0E;
        new_seg[0] = 8'h99; new_seg[1] = 8'hB0; new_seg[2] = 8'hA4; new_seg[3] = 8'hF9;
        sync_frame();
        for (int j = 1; j < 48; j++) begin
            if (j == 8) begin
                i_digits = {5'h01, 5'h02, 5'h03, 5'h04};
                i_load = 1'b1;
            end
            step();
            i_load = 1'b0;
            e = (j % 6 == 0) ? 8'hFF : ((j < 24) ? old_seg[(j / 6) % 4] : new_seg[(j / 6) % 4]);
            checks += 2;
            if (o_seg !== e) begin
                failures++; $display("FAIL midload_seg j=%0d: o_seg=%h required %h", j, o_seg, e);
            end
            if (o_frame !== (j == 24)) begin
                failures++; $display("FAIL midload_frame j=%0d: o_frame=%b", j, o_frame);
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [7:0] old_seg [4];
        logic [7:0] new_seg [4];
        logic [7:0] e;
        old_seg[0] = 8'h99; old_seg[1] = 8'hB0; old_seg[2] = 8'hA4; old_seg[3] = 8'hF9;
        new_seg[0] = 8'h03; new_seg[1] = 8'h46; new_seg[2] = 8'h21; new_seg[3] = 8'h06;
        sync_frame();
        for (int j = 1; j < 72; j++) begin
            if (j == 24) begin
                i_digits = {5'h1E, 5'h1D, 5'h1C, 5'h1B};
                i_load = 1'b1;
            end
            step();
            i_load = 1'b0;
            if (j % 6 != 0) begin
                e = (j < 48) ? old_seg[(j / 6) % 4] : new_seg[(j / 6) % 4];
                checks++;
                if (o_seg !== e) begin
                    failures++; $display("FAIL bndload_seg j=%0d: o_seg=%h required %h", j, o_seg, e);
                end
            end
        end
    endtask

    task automatic test_zero_codes();
        logic [7:0] exp_seg [4];
        logic [3:0] ea;
        logic [19:0] vec [2];
        vec[0] = {5'h00, 5'h10, 5'h00, 5'h03};
        vec[1] = 20'h0;
        for (int v = 0; v < 2; v++) begin
            if (v == 0) begin
                exp_seg[0] = 8'hB0; exp_seg[1] = 8'hC0; exp_seg[2] = 8'h40; exp_seg[3] = 8'hC0;
            end else begin
                exp_seg[0] = 8'hC0; exp_seg[1] = 8'hC0; exp_seg[2] = 8'hC0; exp_seg[3] = 8'hC0;
            end
`ifdef LED_SCAN_LZB_EN
            exp_seg[3] = 8'hFF;
            if (v == 1) begin
                exp_seg[1] = 8'hFF; exp_seg[2] = 8'hFF;
            end
`endif
            sync_frame();
            i_digits = vec[v];
            i_load = 1'b1;
            step();
            i_load = 1'b0;
            sync_frame();
            for (int j = 1; j < 24; j++) begin
                step();
                if (j % 6 != 0) begin
                    ea = (exp_seg[j / 6] == 8'hFF) ? 4'hF : exp_an(j);
                    checks += 2;
                    if (o_an !== ea) begin
                        failures++; $display("FAIL zero%0d_an j=%0d: o_an=%h required %h", v, j, o_an, ea);
                    end
                    if (o_seg !== exp_seg[j / 6]) begin
                        failures++;
                        $display("FAIL zero%0d_seg j=%0d: o_seg=%h required %h", v, j, o_seg, exp_seg[j / 6]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        sync_frame();
        for (int j = 1; j <= 14; j++) begin
            if (j == 3) begin
                i_digits = {5'h01, 5'h02, 5'h03, 5'h04};
                i_load = 1'b1;
            end
            step();
            i_load = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks += 3;
        if (o_an !== 4'hF) begin
            failures++; $display("FAIL rstmid_an: o_an=%h required F", o_an);
        end
        if (o_seg !== 8'hFF) begin
            failures++; $display("FAIL rstmid_seg: o_seg=%h required FF", o_seg);
        end
        if (o_frame !== 1'b0) begin
            failures++; $display("FAIL rstmid_frame: o_frame=%b required 0", o_frame);
        end
        step();
        checks++;
        if (o_frame !== 1'b1) begin
            failures++; $display("FAIL rstmid_restart: o_frame=%b required 1", o_frame);
        end
        for (int j = 1; j < 24; j++) begin
            step();
            if (j % 6 != 0) begin
                e = 8'hC0;
`ifdef LED_SCAN_LZB_EN
                if (j >= 6) e = 8'hFF;
`endif
                checks++;
                if (o_seg !== e) begin
                    failures++; $display("FAIL rstmid_seg j=%0d: o_seg=%h required %h", j, o_seg, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_mid_load();
        test_boundary_load();
        test_zero_codes();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
